// File: rtl/issue_queue_free_list_pkg.sv
// Shared scheduler types for the issue queue and its free list.
package SchedulerTypes;

    localparam int ISSUE_QUEUE_ENTRY_NUM     = 16;
    localparam int ISSUE_QUEUE_INDEX_WIDTH   = $clog2(ISSUE_QUEUE_ENTRY_NUM);
    localparam int ISSUE_QUEUE_ALLOC_WIDTH   = 2;
    localparam int ISSUE_QUEUE_RELEASE_WIDTH = 4;

    typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0]           IssueQueueIndexPath;
    typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM+1)-1:0]   IssueQueueFreeListCountPath;

    typedef enum logic {
        PHASE_INIT  = 1'b0,
        PHASE_READY = 1'b1
    } IssueQueueFreeListPhase;

endpackage

// File: rtl/issue_queue_free_list_compactor.sv
// Prefix sum over release lanes: each valid lane gets its slot offset past
// the tail, so scattered release lanes land in consecutive list positions.
module iq_free_list_compactor #(
    parameter int RELEASE_WIDTH = 4,
    parameter int OFS_WIDTH     = $clog2(RELEASE_WIDTH + 1)
) (
    input  logic [RELEASE_WIDTH-1:0]                i_valid,
    output logic [RELEASE_WIDTH-1:0][OFS_WIDTH-1:0] o_offset,
    output logic [OFS_WIDTH-1:0]                    o_count
);

    logic [OFS_WIDTH-1:0] w_sum;

    // Running count of valid lanes below each lane gives that lane's offset.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional logic so no path leaves it unassigned (no latch).
        o_offset = '0;
        w_sum    = '0;
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            o_offset[j] = w_sum;
            w_sum       = w_sum + OFS_WIDTH'(i_valid[j]);
        end
        o_count = w_sum;
    end

endmodule

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices: hands out up to
// ALLOC_WIDTH indices per cycle from the head, takes back up to
// RELEASE_WIDTH indices per cycle at the tail, and refills itself with
// every index after reset or flush.
module issue_queue_free_list
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM     = ISSUE_QUEUE_ENTRY_NUM,
    parameter int INDEX_WIDTH   = $clog2(ENTRY_NUM),
    parameter int ALLOC_WIDTH   = ISSUE_QUEUE_ALLOC_WIDTH,
    parameter int RELEASE_WIDTH = ISSUE_QUEUE_RELEASE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ALLOC_WIDTH-1:0]               allocate,
    output logic [ALLOC_WIDTH*INDEX_WIDTH-1:0]   allocatedPtr,
    output logic                                 allocatable,
    input  logic [RELEASE_WIDTH-1:0]             releaseValid,
    input  logic [RELEASE_WIDTH*INDEX_WIDTH-1:0] releasePtr,
    output logic [$clog2(ENTRY_NUM+1)-1:0]       freeCount,
    output logic                                 error
);

    localparam int COUNT_WIDTH = $clog2(ENTRY_NUM + 1);
    localparam int SUM_WIDTH   = COUNT_WIDTH + 1;
    localparam int OFS_WIDTH   = $clog2(RELEASE_WIDTH + 1);
    localparam int AREQ_WIDTH  = $clog2(ALLOC_WIDTH + 1);

    IssueQueueFreeListPhase r_state, w_state_next;
    logic [INDEX_WIDTH-1:0] r_init_ptr, w_init_ptr_next;
    logic [INDEX_WIDTH-1:0] r_head, w_head_next;
    logic [INDEX_WIDTH-1:0] r_tail, w_tail_next;
    logic [COUNT_WIDTH-1:0] r_count, w_count_next;
    logic                   r_error, w_error_next;
    logic [INDEX_WIDTH-1:0] r_mem [ENTRY_NUM];

    logic                                   w_allocatable;
    logic [AREQ_WIDTH-1:0]                  w_alloc_req;
    logic [AREQ_WIDTH-1:0]                  w_n_alloc;
    logic                                   w_prefix_ok;
    logic [RELEASE_WIDTH-1:0][OFS_WIDTH-1:0] w_offset;
    logic [OFS_WIDTH-1:0]                   w_n_release;
    logic [SUM_WIDTH-1:0]                   w_sum;
    logic                                   w_overflow;

    iq_free_list_compactor #(
        .RELEASE_WIDTH (RELEASE_WIDTH),
        .OFS_WIDTH     (OFS_WIDTH)
    ) u_compactor (
        .i_valid  (releaseValid),
        .o_offset (w_offset),
        .o_count  (w_n_release)
    );

    // Allocation qualification, request popcount and count bookkeeping.
    always_comb begin
        w_allocatable = (r_state == PHASE_READY) && (r_count >= COUNT_WIDTH'(ALLOC_WIDTH));
        w_alloc_req   = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_alloc_req = w_alloc_req + AREQ_WIDTH'(allocate[i]);
        end
        // A contiguous prefix from lane 0 has no set bit above a clear bit.
        w_prefix_ok = ((allocate & (allocate + ALLOC_WIDTH'(1))) == '0);
        w_n_alloc   = w_allocatable ? w_alloc_req : '0;
        w_sum       = SUM_WIDTH'(r_count) - SUM_WIDTH'(w_n_alloc) + SUM_WIDTH'(w_n_release);
        w_overflow  = (w_sum > SUM_WIDTH'(ENTRY_NUM));
    end

    // Next-state logic for the INIT/READY phases, pointers, count and error.
    always_comb begin
        w_state_next    = r_state;
        w_init_ptr_next = r_init_ptr;
        w_head_next     = r_head;
        w_tail_next     = r_tail;
        w_count_next    = r_count;
        w_error_next    = r_error;
        case (r_state)
            PHASE_INIT: begin
                w_init_ptr_next = r_init_ptr + INDEX_WIDTH'(RELEASE_WIDTH);
                if (r_init_ptr == INDEX_WIDTH'(ENTRY_NUM - RELEASE_WIDTH)) begin
                    w_state_next = PHASE_READY;
                    w_count_next = COUNT_WIDTH'(ENTRY_NUM);
                    w_head_next  = '0;
                    w_tail_next  = '0;
                end
            end
            PHASE_READY: begin
                w_head_next = r_head + INDEX_WIDTH'(w_n_alloc);
                if ((allocate != '0) && !w_allocatable) w_error_next = 1'b1;
                if (!w_prefix_ok)                       w_error_next = 1'b1;
                if (w_overflow) begin
                    // Too many returns: drop every release this cycle so the
                    // list never holds more than ENTRY_NUM indices.
                    w_error_next = 1'b1;
                    w_count_next = r_count - COUNT_WIDTH'(w_n_alloc);
                end else begin
                    w_tail_next  = r_tail + INDEX_WIDTH'(w_n_release);
                    w_count_next = w_sum[COUNT_WIDTH-1:0];
                end
            end
            default: w_state_next = PHASE_INIT;
        endcase
        if (flush) begin
            w_state_next    = PHASE_INIT;
            w_init_ptr_next = '0;
            w_head_next     = '0;
            w_tail_next     = '0;
            w_count_next    = '0;
            w_error_next    = r_error;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= PHASE_INIT;
            r_init_ptr <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this clock edge.
            r_state    <= w_state_next;
            r_init_ptr <= w_init_ptr_next;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_count    <= w_count_next;
            r_error    <= w_error_next;
        end
    end

    // Entry storage: init fill, then compacted release writes at the tail.
    // NOTE: the array has no reset; INIT writes every slot before any read
    // is exposed, and allocatedPtr is forced to zero until then.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (r_state == PHASE_INIT) begin
                for (int k = 0; k < RELEASE_WIDTH; k++) begin
                    r_mem[r_init_ptr + INDEX_WIDTH'(k)] <= r_init_ptr + INDEX_WIDTH'(k);
                end
            end else if (!w_overflow) begin
                for (int j = 0; j < RELEASE_WIDTH; j++) begin
                    if (releaseValid[j]) begin
                        r_mem[r_tail + INDEX_WIDTH'(w_offset[j])] <= releasePtr[j*INDEX_WIDTH +: INDEX_WIDTH];
                    end
                end
            end
        end
    end

    // Head-relative read of the next ALLOC_WIDTH free indices.
    always_comb begin
        allocatedPtr = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (w_allocatable) begin
                allocatedPtr[i*INDEX_WIDTH +: INDEX_WIDTH] = r_mem[r_head + INDEX_WIDTH'(i)];
            end
        end
    end

    assign allocatable = w_allocatable;
    assign freeCount   = r_count;
    assign error       = r_error;

endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed bench for issue_queue_free_list at default parameters.
module tb_issue_queue_free_list;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  allocate;
    logic [7:0]  allocatedPtr;
    logic        allocatable;
    logic [3:0]  releaseValid;
    logic [15:0] releasePtr;
    logic [4:0]  freeCount;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fl;
        logic [1:0]  al;
        logic [3:0]  rl;
        logic [15:0] rp;
        logic        exp_avail;
        logic [7:0]  exp_ptr;
        logic [4:0]  exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    issue_queue_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .allocate     (allocate),
        .allocatedPtr (allocatedPtr),
        .allocatable  (allocatable),
        .releaseValid (releaseValid),
        .releasePtr   (releasePtr),
        .freeCount    (freeCount),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic [1:0] al, input logic [3:0] rl,
                                input logic [15:0] rp, input logic ea, input logic [7:0] ep,
                                input logic [4:0] ec, input logic ee);
        vec_t v;
        v.fl = fl; v.al = al; v.rl = rl; v.rp = rp;
        v.exp_avail = ea; v.exp_ptr = ep; v.exp_count = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; allocate = '0; releaseValid = '0; releasePtr = '0;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, hold one edge, release.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, " rst allocatable"},  32'(allocatable),  32'd0);
        check({tag, " rst freeCount"},    32'(freeCount),    32'd0);
        check({tag, " rst allocatedPtr"}, 32'(allocatedPtr), 32'd0);
        check({tag, " rst error"},        32'(error),        32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Exactly four INIT cycles, then the full list with identity contents.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s init%0d allocatable", tag, i), 32'(allocatable), 32'd0);
            check($sformatf("%s init%0d freeCount", tag, i),   32'(freeCount),   32'd0);
            @(posedge clk); #1;
        end
        check({tag, " ready allocatable"},  32'(allocatable),  32'd1);
        check({tag, " ready freeCount"},    32'(freeCount),    32'd16);
        check({tag, " ready allocatedPtr"}, 32'(allocatedPtr), 32'h10);
        check({tag, " ready error"},        32'(error),        32'd0);
    endtask

    // Each row: drive inputs, compare current outputs, then clock the row in.
    task automatic run_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            flush        = vecs[i].fl;
            allocate     = vecs[i].al;
            releaseValid = vecs[i].rl;
            releasePtr   = vecs[i].rp;
            #1;
            check($sformatf("%s[%0d] allocatable", tag, i),  32'(allocatable),  32'(vecs[i].exp_avail));
            check($sformatf("%s[%0d] allocatedPtr", tag, i), 32'(allocatedPtr), 32'(vecs[i].exp_ptr));
            check($sformatf("%s[%0d] freeCount", tag, i),    32'(freeCount),    32'(vecs[i].exp_count));
            check($sformatf("%s[%0d] error", tag, i),        32'(error),        32'(vecs[i].exp_err));
            @(posedge clk); #1;
        end
        idle_inputs();
        vecs.delete();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        // Power-on reset and initial fill.
        do_reset("por");
        wait_ready("por");

        // Drain all 16 in order, then release {5,9} into an empty list while
        // asking to allocate: error sets and head stays at 0.
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h10, 5'd16, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h32, 5'd14, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h54, 5'd12, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h76, 5'd10, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h98, 5'd8,  0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'hBA, 5'd6,  0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'hDC, 5'd4,  0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'hFE, 5'd2,  0));
        vecs.push_back(mk(0, 2'b11, 4'b0101, 16'h0905, 0, 8'h00, 5'd0, 0));
        vecs.push_back(mk(0, 2'b00, 4'h0, 16'h0000, 1, 8'h95, 5'd2,  1));
        run_vectors("drain");

        // Reset while READY with error set must clear everything at once.
        do_reset("rst2");
        wait_ready("rst2");

        // Move head to 12 and tail to 14 with count 2, then allocate two and
        // release four together so tail wraps 14 -> 2; then fill to overflow.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'((2*i+1) << 4 | (2*i)), 5'(16 - 2*i), 0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'h3210, 0, 8'h00, 5'd0,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'h7654, 1, 8'h10, 5'd4,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'hBA98, 1, 8'h10, 5'd8,  0));
        vecs.push_back(mk(0, 2'b00, 4'h3, 16'h00DC, 1, 8'h10, 5'd12, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'((2*i+1) << 4 | (2*i)), 5'(14 - 2*i), 0));
        vecs.push_back(mk(0, 2'b11, 4'hF, 16'h7654, 1, 8'hDC, 5'd2,  0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h54, 5'd4,  0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h76, 5'd2,  0));
        vecs.push_back(mk(0, 2'b00, 4'h0, 16'h0000, 0, 8'h00, 5'd0,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'h3210, 0, 8'h00, 5'd0,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'h7654, 1, 8'h10, 5'd4,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'hBA98, 1, 8'h10, 5'd8,  0));
        vecs.push_back(mk(0, 2'b00, 4'hF, 16'hFEDC, 1, 8'h10, 5'd12, 0));
        vecs.push_back(mk(0, 2'b00, 4'h1, 16'h0000, 1, 8'h10, 5'd16, 0));
        vecs.push_back(mk(0, 2'b00, 4'h0, 16'h0000, 1, 8'h10, 5'd16, 1));
        run_vectors("wrap");

        do_reset("rst3");
        wait_ready("rst3");

        // Flush at count 7 with a lane-0 allocate: allocation dropped,
        // four INIT cycles, then a fresh full list.
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h10, 5'd16, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h32, 5'd14, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h54, 5'd12, 0));
        vecs.push_back(mk(0, 2'b11, 4'h0, 16'h0000, 1, 8'h76, 5'd10, 0));
        vecs.push_back(mk(0, 2'b01, 4'h0, 16'h0000, 1, 8'h98, 5'd8,  0));
        vecs.push_back(mk(1, 2'b01, 4'h0, 16'h0000, 1, 8'hA9, 5'd7,  0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 2'b00, 4'h0, 16'h0000, 0, 8'h00, 5'd0, 0));
        vecs.push_back(mk(0, 2'b00, 4'h0, 16'h0000, 1, 8'h10, 5'd16, 0));
        run_vectors("flush");

        // Reset pulse in the second INIT cycle restarts the fill from 0.
        do_reset("rst4");
        @(posedge clk); #1;
        do_reset("rst4mid");
        wait_ready("rst4mid");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
